// File: rtl/data_parse_pkg.sv
// Shared packet-format constants for the packet builder and parser.
// Contents: bag/head codes, DLINK magic word, data bag geometry, parser states,
// and the head-nibble to bag-type decode.
package data_parse_pkg;

   localparam int ADDR_W   = 12;
   localparam int DATA_LEN = 64;
   localparam int CHIP_NUM = 8;

   localparam logic [3:0] BAG_NONE  = 4'b0000;
   localparam logic [3:0] BAG_DLINK = 4'b1000;
   localparam logic [3:0] BAG_DTYPE = 4'b1001;
   localparam logic [3:0] BAG_DTEMP = 4'b1010;
   localparam logic [3:0] BAG_DATA  = 4'b1101;

   localparam logic [3:0] HEAD_DLINK = 4'hD;
   localparam logic [3:0] HEAD_DTYPE = 4'h1;
   localparam logic [3:0] HEAD_DTEMP = 4'h9;
   localparam logic [3:0] HEAD_DATA  = 4'h3;

   localparam logic [11:0] DATA_DLINK = 12'h123;

   typedef enum logic [2:0] {
      MAIN_IDLE,
      MAIN_WAIT,
      RD_HEAD,
      HEAD_LAT,
      DECODE,
      BODY,
      MAIN_DONE
   } state_t;

   // Unknown head nibbles map to BAG_NONE, which the parser treats as a parse error.
   function automatic logic [3:0] head_to_bag(input logic [3:0] head);
      logic [3:0] bag;
      case (head)
         HEAD_DLINK: bag = BAG_DLINK;
         HEAD_DTYPE: bag = BAG_DTYPE;
         HEAD_DTEMP: bag = BAG_DTEMP;
         HEAD_DATA:  bag = BAG_DATA;
         default:    bag = BAG_NONE;
      endcase
      return bag;
   endfunction

endpackage

// File: rtl/chip_lane_demux.sv
// Purpose: steer one sample byte to its chip lane with a one-hot write strobe.
// Latency: combinational; the parent registers the outputs.
// Backpressure: none; downstream FIFOs are sized to absorb a full data bag.
// Ports: vld/chip/din in; txen one-hot (msb = chip index 0), txd lane-packed, idle lanes 0.
module chip_lane_demux #(
   parameter int CHIP_NUM = 8,
   parameter int CHIP_W   = $clog2(CHIP_NUM)
) (
   input  logic                  vld,
   input  logic [CHIP_W-1:0]     chip,
   input  logic [7:0]            din,
   output logic [CHIP_NUM-1:0]   txen,
   output logic [CHIP_NUM*8-1:0] txd
);

   // Chip 0 owns the most significant lane, so the bit position is reversed.
   logic [CHIP_W-1:0] lane;
   logic [CHIP_W+2:0] base;

   assign lane = CHIP_W'(CHIP_NUM - 1) - chip;
   assign base = {lane, 3'b000};

   always_comb begin
      txen = '0;
      txd  = '0;
      if (vld) begin
         txen[lane]      = 1'b1;
         txd[base +: 8]  = din;
      end
   end

endmodule

// File: rtl/data_parse.sv
// Purpose: read one packet from RX packet RAM, decode the head, route DATA samples to chip FIFOs.
// Latency: head decoded 3 clk after fs; body streams one byte/clk, fifo write 1 clk after RAM data.
// Backpressure: none; fs/fd level handshake, fs only accepted in MAIN_WAIT.
// Ports: clk/rst; fs in, fd out; ram_addr_init/ram_rxa/ram_rxd RAM read port;
//        decoded fields btype..parse_err; fifo_txen/fifo_txd per-chip sample writes.
module data_parse
   import data_parse_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fs,
   output logic                  fd,
   input  logic [ADDR_W-1:0]     ram_addr_init,
   output logic [ADDR_W-1:0]     ram_rxa,
   input  logic [7:0]            ram_rxd,
   output logic [3:0]            btype,
   output logic [3:0]            device_idx,
   output logic [7:0]            device_type,
   output logic [7:0]            device_temp,
   output logic [3:0]            data_idx,
   output logic [3:0]            device_stat,
   output logic                  link_ok,
   output logic                  parse_err,
   output logic [CHIP_NUM-1:0]   fifo_txen,
   output logic [CHIP_NUM*8-1:0] fifo_txd
);

   localparam int         CHIP_W    = $clog2(CHIP_NUM);
   localparam int         LEN_LG    = $clog2(DATA_LEN);
   localparam logic [9:0] DATA_LAST = 10'(CHIP_NUM * DATA_LEN + 1);

   state_t state, state_nxt;

   // iidx: index of the byte whose address is on ram_rxa; bidx: index of the byte on ram_rxd.
   logic [9:0]            iidx, bidx;
   logic                  iss;      // still issuing body addresses
   logic                  dvld;     // ram_rxd carries body byte bidx
   logic                  done_p;   // last body byte was consumed last clk
   logic [3:0]            head_bag;
   logic [9:0]            last_idx;
   logic [9:0]            samp_off;
   logic [CHIP_W-1:0]     samp_chip;
   logic                  samp_vld;
   logic [CHIP_NUM-1:0]   txen_c;
   logic [CHIP_NUM*8-1:0] txd_c;

   assign head_bag  = head_to_bag(ram_rxd[7:4]);
   assign last_idx  = (btype == BAG_DATA) ? DATA_LAST : 10'd1;
   assign samp_off  = bidx - 10'd2;
   assign samp_chip = CHIP_W'(samp_off >> LEN_LG);
   assign samp_vld  = dvld && (btype == BAG_DATA) && (bidx >= 10'd2);
   assign fd        = (state == MAIN_DONE);

   chip_lane_demux #(.CHIP_NUM(CHIP_NUM), .CHIP_W(CHIP_W)) u_demux (
      .vld  (samp_vld),
      .chip (samp_chip),
      .din  (ram_rxd),
      .txen (txen_c),
      .txd  (txd_c)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= MAIN_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         MAIN_IDLE: state_nxt = MAIN_WAIT;
         MAIN_WAIT: if (fs) state_nxt = RD_HEAD;
         RD_HEAD:   state_nxt = HEAD_LAT;
         HEAD_LAT:  state_nxt = DECODE;
         DECODE:    state_nxt = (head_bag == BAG_NONE) ? MAIN_DONE : BODY;
         // done_p lags the last byte by one clk so the final fifo write lands inside BODY.
         BODY:      if (done_p) state_nxt = MAIN_DONE;
         MAIN_DONE: if (!fs) state_nxt = MAIN_WAIT;
         default:   state_nxt = MAIN_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ram_rxa     <= '0;
         iidx        <= '0;
         bidx        <= '0;
         iss         <= 1'b0;
         dvld        <= 1'b0;
         done_p      <= 1'b0;
         btype       <= BAG_NONE;
         device_idx  <= '0;
         device_type <= '0;
         device_temp <= '0;
         data_idx    <= '0;
         device_stat <= '0;
         link_ok     <= 1'b0;
         parse_err   <= 1'b0;
         fifo_txen   <= '0;
         fifo_txd    <= '0;
      end else begin
         dvld      <= 1'b0;
         done_p    <= 1'b0;
         fifo_txen <= txen_c;
         fifo_txd  <= txd_c;
         case (state)
            MAIN_WAIT: begin
               if (fs) begin
                  ram_rxa     <= ram_addr_init;
                  btype       <= BAG_NONE;
                  device_idx  <= '0;
                  device_type <= '0;
                  device_temp <= '0;
                  data_idx    <= '0;
                  device_stat <= '0;
                  link_ok     <= 1'b0;
                  parse_err   <= 1'b0;
               end
            end
            DECODE: begin
               btype      <= head_bag;
               device_idx <= ram_rxd[3:0];
               parse_err  <= (head_bag == BAG_NONE);
               iss        <= (head_bag != BAG_NONE);
               ram_rxa    <= ram_rxa + 1'b1;
               iidx       <= 10'd1;
            end
            BODY: begin
               if (iss) begin
                  if (iidx == last_idx) begin
                     iss <= 1'b0;
                  end else begin
                     ram_rxa <= ram_rxa + 1'b1;
                     iidx    <= iidx + 10'd1;
                  end
               end
               dvld <= iss;
               bidx <= iidx;
               if (dvld && (bidx == 10'd1)) begin
                  case (btype)
                     BAG_DLINK: link_ok     <= ({device_idx, ram_rxd} == DATA_DLINK);
                     BAG_DTYPE: device_type <= ram_rxd;
                     BAG_DTEMP: device_temp <= ram_rxd;
                     BAG_DATA:  {data_idx, device_stat} <= ram_rxd;
                     default:   ;
                  endcase
               end
               done_p <= dvld && (bidx == last_idx);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_data_parse.sv
module tb_data_parse;
   import data_parse_pkg::*;

   logic        clk = 1'b0;
   logic        rst, fs, fd, link_ok, parse_err;
   logic [11:0] ram_addr_init, ram_rxa;
   logic [7:0]  ram_rxd, device_type, device_temp, fifo_txen;
   logic [3:0]  btype, device_idx, data_idx, device_stat;
   logic [63:0] fifo_txd;

   always #5 clk = ~clk;

   data_parse dut (
      .clk(clk), .rst(rst), .fs(fs), .fd(fd),
      .ram_addr_init(ram_addr_init), .ram_rxa(ram_rxa), .ram_rxd(ram_rxd),
      .btype(btype), .device_idx(device_idx), .device_type(device_type),
      .device_temp(device_temp), .data_idx(data_idx), .device_stat(device_stat),
      .link_ok(link_ok), .parse_err(parse_err),
      .fifo_txen(fifo_txen), .fifo_txd(fifo_txd)
   );

   // Synchronous-read packet RAM: data one clk after address.
   logic [7:0] mem [0:4095];
   always @(posedge clk) ram_rxd <= mem[ram_rxa];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { logic [7:0] en; logic [63:0] d; int c; } wr_t;
   wr_t         wq[$];
   logic [11:0] addr_q[$];
   bit          rec_addr = 0;
   int          fd_cyc = -1;
   logic        fd_q = 1'b0;

   always @(negedge clk) begin
      if (fifo_txen != 8'h00) wq.push_back('{fifo_txen, fifo_txd, cyc});
      if (fd && !fd_q) fd_cyc = cyc;
      fd_q = fd;
      if (rec_addr && (addr_q.size() == 0 || addr_q[$] != ram_rxa)) addr_q.push_back(ram_rxa);
   end

   int n_run = 0, n_fail = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic start_pkt(input logic [11:0] a);
      @(negedge clk);
      ram_addr_init = a;
      fs            = 1'b1;
      wq.delete();
      fd_cyc        = -1;
   endtask

   task automatic wait_fd(input string name, input int bound);
      int n = 0;
      while (fd !== 1'b1 && n < bound) begin
         @(negedge clk);
         n++;
      end
      check({name, "_fd"}, 128'(fd), 128'(1));
   endtask

   task automatic end_pkt();
      @(negedge clk);
      fs = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   typedef struct {
      logic [11:0] init;
      logic [7:0]  b0, b1;
      logic [3:0]  btype, didx;
      logic [7:0]  dtype, dtemp;
      logic        link, perr;
   } vec_t;
   vec_t vt[7];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
      vt[0] = '{12'h100, 8'hD1, 8'h23, 4'b1000, 4'h1, 8'h00, 8'h00, 1'b1, 1'b0};
      vt[1] = '{12'h200, 8'h15, 8'hA7, 4'b1001, 4'h5, 8'hA7, 8'h00, 1'b0, 1'b0};
      vt[2] = '{12'hFFF, 8'h9A, 8'h3C, 4'b1010, 4'hA, 8'h00, 8'h3C, 1'b0, 1'b0};
      vt[3] = '{12'h300, 8'h70, 8'h55, 4'b0000, 4'h0, 8'h00, 8'h00, 1'b0, 1'b1};
      vt[4] = '{12'h400, 8'hD1, 8'h24, 4'b1000, 4'h1, 8'h00, 8'h00, 1'b0, 1'b0};
      vt[5] = '{12'h500, 8'hD2, 8'h23, 4'b1000, 4'h2, 8'h00, 8'h00, 1'b0, 1'b0};
      vt[6] = '{12'h600, 8'h1F, 8'h00, 4'b1001, 4'hF, 8'h00, 8'h00, 1'b0, 1'b0};

      rst = 1'b1; fs = 1'b0; ram_addr_init = 12'h000;
      repeat (3) @(negedge clk);
      check("rst_fields", {btype, device_idx, device_type, device_temp, data_idx,
                           device_stat, link_ok, parse_err, fd}, '0);
      check("rst_fifo_addr", {fifo_txen, fifo_txd, ram_rxa}, '0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 7; i++) begin
         logic [11:0] a1;
         int          pos;
         a1 = vt[i].init + 12'd1;
         mem[vt[i].init] = vt[i].b0;
         mem[a1]         = vt[i].b1;
         addr_q.delete();
         rec_addr = 1;
         start_pkt(vt[i].init);
         wait_fd($sformatf("v%0d", i), 100);
         rec_addr = 0;
         end_pkt();
         check($sformatf("v%0d_btype", i), 128'(btype), 128'(vt[i].btype));
         check($sformatf("v%0d_didx", i), 128'(device_idx), 128'(vt[i].didx));
         check($sformatf("v%0d_dtype", i), 128'(device_type), 128'(vt[i].dtype));
         check($sformatf("v%0d_dtemp", i), 128'(device_temp), 128'(vt[i].dtemp));
         check($sformatf("v%0d_link", i), 128'(link_ok), 128'(vt[i].link));
         check($sformatf("v%0d_perr", i), 128'(parse_err), 128'(vt[i].perr));
         check($sformatf("v%0d_dstat", i), 128'({data_idx, device_stat}), 128'(0));
         check($sformatf("v%0d_nowr", i), 128'(wq.size()), 128'(0));
         if (!vt[i].perr) begin
            pos = -1;
            foreach (addr_q[j]) if (pos < 0 && addr_q[j] == vt[i].init) pos = j;
            check($sformatf("v%0d_addr_seq", i),
                  128'((pos >= 0) && (pos + 1 < addr_q.size()) && (addr_q[pos+1] == a1)),
                  128'(1));
         end
      end

      // Full data bag; fs is dropped early and the packet must still complete.
      mem[0] = 8'h33; mem[1] = 8'h6C;
      for (int k = 0; k < 512; k++) mem[k+2] = 8'(k);
      start_pkt(12'h000);
      repeat (5) @(negedge clk);
      fs = 1'b0;
      wait_fd("data", 1500);
      repeat (3) @(negedge clk);
      check("data_btype", 128'(btype), 128'(4'b1101));
      check("data_didx", 128'(device_idx), 128'(4'h3));
      check("data_idx", 128'(data_idx), 128'(4'h6));
      check("data_stat", 128'(device_stat), 128'(4'hC));
      check("data_cnt", 128'(wq.size()), 128'(512));
      if (wq.size() == 512) begin
         int errs = 0;
         for (int i = 0; i < 512; i++) begin
            logic [7:0]  een;
            logic [63:0] ed;
            een = 8'h80 >> (i / 64);
            ed  = 64'(i % 256) << (8 * (7 - i / 64));
            if (wq[i].en !== een || wq[i].d !== ed) errs++;
         end
         check("data_stream_errs", 128'(errs), 128'(0));
         check("data_first", {wq[0].en, wq[0].d}, {8'h80, 64'h00});
         check("data_last", {wq[511].en, wq[511].d}, {8'h01, 64'hFF});
         check("data_no_bubble", 128'(wq[511].c - wq[0].c), 128'(511));
         check("data_fd_timing", 128'(fd_cyc), 128'(wq[511].c + 1));
      end

      // Reset in the middle of a data bag, then a fresh packet.
      start_pkt(12'h000);
      begin
         int n = 0;
         while (wq.size() < 98 && n < 500) begin
            @(negedge clk);
            n++;
         end
         check("mid_reached", 128'(wq.size() >= 98), 128'(1));
      end
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_fields", {btype, device_idx, device_type, device_temp, data_idx,
                               device_stat, link_ok, parse_err, fd}, '0);
      check("mid_rst_fifo_addr", {fifo_txen, fifo_txd, ram_rxa}, '0);
      begin
         int n0;
         rst = 1'b0; fs = 1'b0;
         n0 = wq.size();
         repeat (20) @(negedge clk);
         check("mid_no_wr_after", 128'(wq.size() - n0), 128'(0));
      end
      mem[12'h700] = 8'h12; mem[12'h701] = 8'h5B;
      start_pkt(12'h700);
      wait_fd("post_rst", 100);
      end_pkt();
      check("post_rst_fields", {btype, device_idx, device_type, device_temp, data_idx, device_stat},
            {4'b1001, 4'h2, 8'h5B, 8'h00, 4'h0, 4'h0});
      check("post_rst_nowr", 128'(wq.size()), 128'(0));

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
